// File: rtl/lmk04828_init_seq_if.sv
// Frame handshake between the LMK04828 init sequencer and the SPI shifter.
// The shifter raises spi_done once per accepted frame and returns spi_rdata alongside it.
interface lmk04828_init_seq_if;
  logic        spi_valid;
  logic [23:0] spi_data;
  logic        spi_ready;
  logic        spi_done;
  logic [7:0]  spi_rdata;

  modport master (output spi_valid, spi_data, input spi_ready, spi_done, spi_rdata);
  modport slave  (input spi_valid, spi_data, output spi_ready, spi_done, spi_rdata);
endinterface

// File: rtl/lmk04828_init_seq.sv
// LMK04828 power-up sequencer: streams a register table out as SPI frames, then
// polls the lock status register until the lock bits are set or the retries run out.
module lmk04828_init_seq #(
  parameter int          TBL_AW     = 8,
  parameter int          RST_DELAY  = 5000,
  parameter int          GAP_CYCLES = 16,
  parameter logic [14:0] POLL_ADDR  = 15'h0183,
  parameter logic [7:0]  POLL_MASK  = 8'h06,
  parameter int          POLL_TRIES = 64,
  parameter int          POLL_GAP   = 100000
) (
  input  logic                slmb_aclk,
  input  logic                slmb_aresetn,
  input  logic                start,
  input  logic [TBL_AW:0]     tbl_len,
  output logic [TBL_AW-1:0]   tbl_addr,
  input  logic [23:0]         tbl_data,
  lmk04828_init_seq_if.master spi,
  output logic                busy,
  output logic                done,
  output logic                error,
  output logic [7:0]          poll_cnt
);

  typedef enum logic [3:0] {
    S_IDLE, S_FETCH, S_WAIT_ROM, S_ISSUE, S_WAIT_DONE, S_DELAY,
    S_POLL_ISSUE, S_POLL_WAIT, S_POLL_GAP, S_FINISH, S_FAIL
  } state_t;

  localparam int unsigned     TBL_MAX_I  = 1 << TBL_AW;
  localparam logic [TBL_AW:0] TBL_MAX    = TBL_MAX_I[TBL_AW:0];
  localparam logic [31:0]     RST_DLY    = 32'(RST_DELAY);
  localparam logic [31:0]     GAP_DLY    = 32'(GAP_CYCLES);
  localparam logic [31:0]     PGAP_DLY   = 32'(POLL_GAP);
  localparam logic [31:0]     TRIES      = 32'(POLL_TRIES);
  localparam logic [23:0]     POLL_FRAME = {1'b1, POLL_ADDR, 8'h00};

  state_t              state_q, state_d;
  logic [TBL_AW:0]     idx_q, idx_d, idx_inc;
  logic [TBL_AW:0]     len_q, len_d;
  logic [31:0]         dly_q, dly_d;
  logic                vld_q, vld_d;
  logic [23:0]         data_q, data_d;
  logic [TBL_AW-1:0]   addr_q, addr_d;
  logic                busy_q, busy_d, done_q, done_d, err_q, err_d;
  logic [7:0]          pcnt_q, pcnt_d;
  logic                arm_q;

  always_ff @(posedge slmb_aclk) begin
    if (!slmb_aresetn) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      len_q   <= '0;
      dly_q   <= '0;
      vld_q   <= 1'b0;
      data_q  <= '0;
      addr_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      pcnt_q  <= '0;
      arm_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      len_q   <= len_d;
      dly_q   <= dly_d;
      vld_q   <= vld_d;
      data_q  <= data_d;
      addr_q  <= addr_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
      pcnt_q  <= pcnt_d;
      // start is only honoured once reset has been released for a full cycle
      arm_q   <= 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    len_d   = len_q;
    dly_d   = dly_q;
    vld_d   = vld_q;
    data_d  = data_q;
    addr_d  = addr_q;
    busy_d  = busy_q;
    done_d  = done_q;
    err_d   = err_q;
    pcnt_d  = pcnt_q;
    idx_inc = idx_q + 1'b1;

    case (state_q)
      S_IDLE: if (start && arm_q) begin
        done_d  = 1'b0;
        err_d   = 1'b0;
        pcnt_d  = '0;
        idx_d   = '0;
        addr_d  = '0;
        busy_d  = 1'b1;
        len_d   = (tbl_len > TBL_MAX) ? TBL_MAX : tbl_len;
        state_d = (tbl_len == '0) ? S_POLL_ISSUE : S_FETCH;
      end
      // tbl_addr is already valid here, so the registered ROM answers in WAIT_ROM
      S_FETCH: state_d = S_WAIT_ROM;
      S_WAIT_ROM: begin
        data_d  = tbl_data;
        vld_d   = 1'b1;
        state_d = S_ISSUE;
      end
      S_ISSUE: if (spi.spi_ready) begin
        vld_d   = 1'b0;
        state_d = S_WAIT_DONE;
      end
      S_WAIT_DONE: if (spi.spi_done) begin
        dly_d   = (idx_q == '0) ? RST_DLY : GAP_DLY;
        state_d = S_DELAY;
      end
      S_DELAY: begin
        if (dly_q == '0) begin
          idx_d = idx_inc;
          if (idx_inc == len_q) state_d = S_POLL_ISSUE;
          else begin
            addr_d  = idx_inc[TBL_AW-1:0];
            state_d = S_FETCH;
          end
        end else dly_d = dly_q - 1'b1;
      end
      S_POLL_ISSUE: if (vld_q && spi.spi_ready) begin
        vld_d   = 1'b0;
        pcnt_d  = (pcnt_q == 8'hFF) ? pcnt_q : pcnt_q + 1'b1;
        state_d = S_POLL_WAIT;
      end
      S_POLL_WAIT: if (spi.spi_done) begin
        if ((spi.spi_rdata & POLL_MASK) == POLL_MASK) state_d = S_FINISH;
        else if ({24'd0, pcnt_q} >= TRIES)            state_d = S_FAIL;
        else begin
          dly_d   = PGAP_DLY;
          state_d = S_POLL_GAP;
        end
      end
      S_POLL_GAP: begin
        if (dly_q == '0) state_d = S_POLL_ISSUE;
        else dly_d = dly_q - 1'b1;
      end
      S_FINISH: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      S_FAIL: begin
        err_d   = 1'b1;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // every entry into POLL_ISSUE presents the status read with valid already high
    if (state_d == S_POLL_ISSUE && state_q != S_POLL_ISSUE) begin
      vld_d  = 1'b1;
      data_d = POLL_FRAME;
    end
  end

  assign spi.spi_valid = vld_q;
  assign spi.spi_data  = data_q;
  assign tbl_addr      = addr_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign error         = err_q;
  assign poll_cnt      = pcnt_q;

endmodule

// File: tb/tb_lmk04828_init_seq.sv
// Bench for lmk04828_init_seq: ROM + SPI shifter model, frame/gap scoreboard
// derived from the table, the poll readback list and the sequencing rules.
module tb_lmk04828_init_seq;
  localparam int AW = 3, RSTD = 5000, GAP = 16, TRIES = 4, PGAP = 200;
  localparam int TMAX = 1 << AW;
  localparam logic [23:0] PFRM = 24'h818300;

  logic          slmb_aclk = 1'b0, slmb_aresetn = 1'b0, start = 1'b0;
  logic [AW:0]   tbl_len = '0;
  logic [AW-1:0] tbl_addr;
  logic [23:0]   tbl_data = '0;
  logic          busy, done, error;
  logic [7:0]    poll_cnt;

  lmk04828_init_seq_if s();

  lmk04828_init_seq #(
    .TBL_AW(AW), .RST_DELAY(RSTD), .GAP_CYCLES(GAP), .POLL_ADDR(15'h0183),
    .POLL_MASK(8'h06), .POLL_TRIES(TRIES), .POLL_GAP(PGAP)
  ) dut (
    .slmb_aclk(slmb_aclk), .slmb_aresetn(slmb_aresetn), .start(start),
    .tbl_len(tbl_len), .tbl_addr(tbl_addr), .tbl_data(tbl_data), .spi(s),
    .busy(busy), .done(done), .error(error), .poll_cnt(poll_cnt)
  );

  always #5 slmb_aclk = ~slmb_aclk;

  logic [23:0] rom [TMAX];
  always @(posedge slmb_aclk) tbl_data <= rom[tbl_addr];

  int n_chk = 0, n_fail = 0;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // shifter model state
  int          cyc = 0, len_eff = 0, ready_mode = 0, lat_lo = 1, lat_hi = 1;
  int          acc_q[$], dn_q[$];
  logic [23:0] frm_q[$];
  logic [7:0]  rd_q[$], rd_ref[$];
  bit          pend = 0, stalled = 0, prv_vld = 0, prv_acc = 0;
  int          pend_at = 0, stall_left = 0, hold_n = 0, hs_viol = 0;
  logic [7:0]  pend_rd = '0;
  logic [23:0] prv_data = '0;

  initial begin
    s.spi_ready = 1'b0; s.spi_done = 1'b0; s.spi_rdata = '0;
    forever begin
      @(negedge slmb_aclk);
      cyc++;
      s.spi_done = 1'b0;
      if (!slmb_aresetn) begin
        prv_vld = 0; pend = 0;
      end else begin
        if (pend && cyc == pend_at) begin
          s.spi_done = 1'b1; s.spi_rdata = pend_rd; pend = 0;
          dn_q.push_back(cyc);
        end
        case (ready_mode)
          1: s.spi_ready = ($urandom_range(0, 2) != 0);
          2: begin
            if (!stalled && s.spi_valid && acc_q.size() == 1) begin
              stalled = 1; stall_left = 20;
            end
            if (stall_left > 0) begin
              s.spi_ready = 1'b0; stall_left--;
              if (s.spi_valid && s.spi_data == 24'h000110) hold_n++;
            end else s.spi_ready = 1'b1;
          end
          default: s.spi_ready = 1'b1;
        endcase
        if (prv_vld && !prv_acc && (!s.spi_valid || s.spi_data != prv_data)) hs_viol++;
        prv_acc = s.spi_valid && s.spi_ready;
        if (prv_acc) begin
          if (pend) hs_viol++;
          acc_q.push_back(cyc);
          frm_q.push_back(s.spi_data);
          pend = 1;
          pend_at = cyc + int'($urandom_range(lat_lo, lat_hi));
          pend_rd = 8'h00;
          if (frm_q.size() > len_eff) pend_rd = (rd_q.size() > 0) ? rd_q.pop_front() : 8'h00;
        end
        prv_vld = s.spi_valid;
        prv_data = s.spi_data;
      end
    end
  end

  task automatic tick();
    @(posedge slmb_aclk); #2;
  endtask

  task automatic start_seq(input int len);
    tbl_len = (AW+1)'(len);
    len_eff = (len > TMAX) ? TMAX : len;
    acc_q.delete(); dn_q.delete(); frm_q.delete();
    rd_q = rd_ref; stalled = 0; hold_n = 0; hs_viol = 0;
    start = 1'b1; tick(); start = 1'b0;
    chk("busy_on", 32'(busy), 1);
    chk("clr_flags", 32'({done, error}), 0);
  endtask

  task automatic wait_end(input bit poke);
    bit poked;
    int k;
    poked = 0;
    for (k = 0; k < 30000; k++) begin
      if (!busy) break;
      start = 1'b0;
      if (poke && !poked && acc_q.size() >= 1) begin start = 1'b1; poked = 1; end
      tick();
    end
    start = 1'b0;
    chk("timeout", 32'(k < 30000), 1);
  endtask

  task automatic check_run();
    int n_ok, npoll, nfr, g, d;
    logic [7:0] v;
    n_ok = -1;
    for (int k = 0; k < TRIES; k++) begin
      v = (k < rd_ref.size()) ? rd_ref[k] : 8'h00;
      if (n_ok < 0 && (v & 8'h06) == 8'h06) n_ok = k;
    end
    npoll = (n_ok >= 0) ? n_ok + 1 : TRIES;
    nfr = len_eff + npoll;
    chk("n_frames", 32'(frm_q.size()), 32'(nfr));
    for (int i = 0; i < frm_q.size() && i < nfr; i++)
      chk($sformatf("frame%0d", i), 32'(frm_q[i]), 32'((i < len_eff) ? rom[i] : PFRM));
    for (int i = 1; i < acc_q.size() && i <= dn_q.size(); i++) begin
      if (i - 1 < len_eff) g = ((i == 1) ? RSTD : GAP) + ((i < len_eff) ? 4 : 2);
      else g = PGAP + 2;
      d = acc_q[i] - dn_q[i-1];
      if (ready_mode == 0) chk($sformatf("gap%0d", i), 32'(d), 32'(g));
      else chk($sformatf("gapmin%0d", i), 32'(d >= g), 1);
    end
    chk("done", 32'(done), 32'(n_ok >= 0));
    chk("error", 32'(error), 32'(n_ok < 0));
    chk("busy_off", 32'(busy), 0);
    chk("poll_cnt", 32'(poll_cnt), 32'(npoll));
    chk("handshake", 32'(hs_viol), 0);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_vld"},  32'(s.spi_valid), 0);
    chk({tag, "_data"}, 32'(s.spi_data), 0);
    chk({tag, "_addr"}, 32'(tbl_addr), 0);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_flags"}, 32'({done, error}), 0);
    chk({tag, "_pcnt"}, 32'(poll_cnt), 0);
  endtask

  logic [7:0] rdv [5] = '{8'h00, 8'h02, 8'h04, 8'h06, 8'hFF};

  initial begin
    for (int i = 0; i < TMAX; i++) rom[i] = '0;
    repeat (3) tick();
    chk_reset_vals("rst");
    // start coincident with reset release must be ignored
    slmb_aresetn = 1'b1; start = 1'b1; tick(); start = 1'b0; tick();
    chk("start_at_release", 32'(busy), 0);

    rom[0] = 24'h000080; rom[1] = 24'h000110; rom[2] = 24'h014000;
    ready_mode = 0; lat_lo = 50; lat_hi = 50; rd_ref = {8'h06};
    start_seq(3); wait_end(0); check_run();

    ready_mode = 2;
    start_seq(3); wait_end(0); check_run();
    chk("stall_hold", 32'(hold_n), 20);

    ready_mode = 0; lat_lo = 10; lat_hi = 30; rd_ref = {8'h02, 8'h02, 8'h02, 8'h06};
    start_seq(3); wait_end(0); check_run();

    rd_ref = {};
    start_seq(3); wait_end(0); check_run();

    // empty table with a start pulse mid-run
    rd_ref = {8'h00, 8'h06};
    start_seq(0); wait_end(1); check_run();

    // reset while in the gap after frame 1, then a full replay
    rd_ref = {8'h06};
    start_seq(3);
    for (int k = 0; k < 20000 && dn_q.size() < 2; k++) tick();
    chk("rst_wait", 32'(dn_q.size() >= 2), 1);
    repeat (5) tick();
    slmb_aresetn = 1'b0; tick();
    chk_reset_vals("midrst");
    slmb_aresetn = 1'b1; repeat (3) tick();
    chk("midrst_idle", 32'(busy), 0);
    start_seq(3); wait_end(0); check_run();

    // oversize table length clamps to the table depth
    for (int i = 0; i < TMAX; i++) rom[i] = 24'(32'h1000 + i);
    lat_lo = 5; lat_hi = 5; rd_ref = {8'h0E};
    start_seq(11); wait_end(0); check_run();

    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < TMAX; i++) rom[i] = 24'($urandom) & 24'h7FFFFF;
      ready_mode = int'($urandom_range(0, 1));
      lat_lo = 1; lat_hi = 20;
      rd_ref.delete();
      repeat ($urandom_range(0, 5)) rd_ref.push_back(rdv[$urandom_range(0, 4)]);
      start_seq(int'($urandom_range(1, 12))); wait_end(0); check_run();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
